// File: rtl/ncl_dualrail_pipe_sync.sv
// rtl/ncl_dualrail_pipe_sync.sv - clocked dual-rail NCL wavefront pipeline, binary valid/ready at both ends
// Optional occupancy counter and port enabled by NCL_OCCUPANCY_EN.
module ncl_dualrail_pipe_sync #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef NCL_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0][WIDTH-1:0] rail1;
  logic [DEPTH-1:0][WIDTH-1:0] rail0;
  logic                        ack;

  logic [DEPTH-1:0] is_data;
  logic [DEPTH-1:0] is_null;
  logic [DEPTH-1:0] down_data;
  logic [DEPTH-1:0] down_null;
  logic [DEPTH-1:0] adv_data;
  logic [DEPTH-1:0] adv_null;
  logic             accept;
  logic             take;

  // Completion detection: a stage is DATA only when every bit has exactly one rail set.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      is_data[i] = &(rail1[i] ^ rail0[i]);
      is_null[i] = ~|(rail1[i] | rail0[i]);
    end
  end

  // The sink ack flop acts as the completion of a virtual stage after the last one.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        down_data[i] = ack;
        down_null[i] = ~ack;
      end else begin
        down_data[i] = is_data[i+1];
        down_null[i] = is_null[i+1];
      end
    end
  end

  always_comb begin
    adv_data    = '0;
    adv_null    = '0;
    adv_data[0] = accept;
    adv_null[0] = ~accept & is_data[0] & is_data[1];
    for (int i = 1; i < DEPTH; i++) begin
      adv_data[i] = is_data[i-1] & is_null[i] & down_null[i];
      adv_null[i] = is_null[i-1] & is_data[i] & down_data[i];
    end
  end

  assign in_ready  = is_null[0] & is_null[1];
  assign accept    = in_valid & in_ready;
  assign out_valid = is_data[DEPTH-1] & ~ack;
  assign out_data  = rail1[DEPTH-1];
  assign take      = out_valid & out_ready;

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      rail1 <= '0;
      rail0 <= '0;
    end else begin
      if (adv_data[0]) begin
        rail1[0] <= in_data;
        rail0[0] <= ~in_data;
      end else if (adv_null[0]) begin
        rail1[0] <= '0;
        rail0[0] <= '0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv_data[i]) begin
          rail1[i] <= rail1[i-1];
          rail0[i] <= rail0[i-1];
        end else if (adv_null[i]) begin
          rail1[i] <= '0;
          rail0[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      ack <= 1'b0;
    end else if (take) begin
      ack <= 1'b1;
    end else if (is_null[DEPTH-1] && ack) begin
      ack <= 1'b0;
    end
  end

`ifdef NCL_OCCUPANCY_EN
  localparam int OW = $clog2(DEPTH + 1);

  logic [OW-1:0] occ_q;

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      occ_q <= '0;
    end else if (accept && !take) begin
      occ_q <= occ_q + OW'(1);
    end else if (take && !accept) begin
      occ_q <= occ_q - OW'(1);
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_ncl_dualrail_pipe_sync.sv
// tb/tb_ncl_dualrail_pipe_sync.sv - scoreboard bench over four pipe configurations
// Occupancy checks compile in when NCL_OCCUPANCY_EN is defined.
module tb_ncl_dualrail_pipe_sync;

  localparam int NI = 4;
  localparam int WS [NI] = '{4, 4, 1, 8};
  localparam int DS [NI] = '{4, 2, 2, 6};

  logic       clk = 1'b0;
  logic       init      [NI];
  logic [7:0] in_data   [NI];
  logic       in_valid  [NI];
  logic       in_ready  [NI];
  logic [7:0] out_data  [NI];
  logic       out_valid [NI];
  logic       out_ready [NI];
  logic [3:0] occ       [NI];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [WS[g]-1:0]           od;
    logic [$clog2(DS[g]+1)-1:0] occ_l;
    logic [7:0]                 sbq [$];
    int                         took = 0;
    logic                       pend = 1'b0;
    logic [7:0]                 pdata = '0;

    ncl_dualrail_pipe_sync #(.WIDTH(WS[g]), .DEPTH(DS[g])) u (
      .clk       (clk),
      .init      (init[g]),
      .in_data   (in_data[g][WS[g]-1:0]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .out_data  (od),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g])
`ifdef NCL_OCCUPANCY_EN
      ,
      .occupancy (occ_l)
`endif
    );

`ifndef NCL_OCCUPANCY_EN
    assign occ_l = '0;
`endif
    assign out_data[g] = 8'(od);
    assign occ[g]      = 4'(occ_l);

    always @(negedge clk) begin
      if (init[g]) begin
        sbq.delete();
        pend = 1'b0;
      end else begin
        if (pend) begin
          check($sformatf("hold_valid[%0d]", g), 32'(out_valid[g]), 32'd1);
          check($sformatf("hold_data[%0d]", g), 32'(out_data[g]), 32'(pdata));
        end
        if (out_valid[g] && out_ready[g]) begin
          took++;
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out[%0d]: got %0h expected no word", g, out_data[g]);
          end else begin
            check($sformatf("order[%0d]", g), 32'(out_data[g]), 32'(sbq.pop_front()));
          end
        end
        if (in_valid[g] && in_ready[g]) sbq.push_back(8'(in_data[g][WS[g]-1:0]));
        pend  = out_valid[g] && !out_ready[g];
        pdata = out_data[g];
`ifdef NCL_OCCUPANCY_EN
        check($sformatf("occ_bound[%0d]", g), 32'(occ[g] <= 4'((DS[g] + 1) / 2)), 32'd1);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer words base, base+1, ... on instance g until n are accepted or the cycle budget runs out.
  task automatic feed(input int g, input int n, input logic [7:0] base, input int budget, output int k);
    logic rdy;
    k = 0;
    in_data[g]  = base;
    in_valid[g] = 1'b1;
    for (int c = 0; c < budget && k < n; c++) begin
      rdy = in_ready[g] && in_valid[g];
      step();
      if (rdy) begin
        k++;
        if (k < n) in_data[g] = base + 8'(k);
        else in_valid[g] = 1'b0;
      end
    end
  endtask

  int  k;
  int  t0;
  int  cyc;
  logic rdy;
  logic [7:0] w1_words [3];

  initial begin
    for (int g = 0; g < NI; g++) begin
      init[g] = 1'b1; in_data[g] = '0; in_valid[g] = 1'b0; out_ready[g] = 1'b0;
    end
    #12;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_in_ready[%0d]", g), 32'(in_ready[g]), 32'd1);
      check($sformatf("rst_out_valid[%0d]", g), 32'(out_valid[g]), 32'd0);
      check($sformatf("rst_out_data[%0d]", g), 32'(out_data[g]), 32'd0);
      check($sformatf("rst_occ[%0d]", g), 32'(occ[g]), 32'd0);
    end
    @(negedge clk);
    for (int g = 0; g < NI; g++) init[g] = 1'b0;

    // Single word 0xA through DEPTH=4: visible after edge 4 for one cycle.
    in_data[0] = 8'hA; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 1) in_valid[0] = 1'b0;
      check($sformatf("single_valid_e%0d", e), 32'(out_valid[0]), 32'(e == 4));
      if (e == 4) check("single_data", 32'(out_data[0]), 32'hA);
    end
    repeat (4) step();
    check("single_idle_ready", 32'(in_ready[0]), 32'd1);
    check("single_took", 32'(g_inst[0].took), 32'd1);

    // Backpressure: only two words fit in DEPTH=4.
    out_ready[0] = 1'b0;
    feed(0, 5, 8'h1, 20, k);
    check("bp_accepted", 32'(k), 32'd2);
    check("bp_in_ready", 32'(in_ready[0]), 32'd0);
`ifdef NCL_OCCUPANCY_EN
    check("bp_occ", 32'(occ[0]), 32'd2);
`endif
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    feed(0, 3, 8'h3, 100, k);
    check("bp_rest_accepted", 32'(k), 32'd3);
    repeat (20) step();
    check("bp_took", 32'(g_inst[0].took), 32'd6);
    check("bp_ready_back", 32'(in_ready[0]), 32'd1);

    // Asynchronous reset with two words in flight.
    out_ready[0] = 1'b0;
    feed(0, 3, 8'h7, 20, k);
    check("mid_fill", 32'(k), 32'd2);
    in_valid[0] = 1'b0;
    #2 init[0] = 1'b1;
    #1;
    check("mid_in_ready", 32'(in_ready[0]), 32'd1);
    check("mid_out_valid", 32'(out_valid[0]), 32'd0);
    check("mid_out_data", 32'(out_data[0]), 32'd0);
    check("mid_occ", 32'(occ[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    init[0] = 1'b0;
    t0 = g_inst[0].took;
    out_ready[0] = 1'b1;
    repeat (12) step();
    check("mid_no_stale", 32'(g_inst[0].took), 32'(t0));

    // DEPTH=2 throughput: in_ready high every fourth cycle.
    in_data[1] = 8'h0; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    for (int c = 0; c < 24; c++) begin
      check($sformatf("tput_ready_c%0d", c), 32'(in_ready[1]), 32'(c % 4 == 0));
      rdy = in_ready[1];
      step();
      if (rdy) in_data[1] = in_data[1] + 8'd1;
    end
    in_valid[1] = 1'b0;
    repeat (10) step();
    check("tput_took", 32'(g_inst[1].took), 32'd6);

    // WIDTH=1 corner: words 1,0,1.
    w1_words = '{8'd1, 8'd0, 8'd1};
    out_ready[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[2] = w1_words[i];
      in_valid[2] = 1'b1;
      cyc = 0;
      rdy = 1'b0;
      while (!rdy && cyc < 20) begin
        rdy = in_ready[2];
        step();
        cyc++;
      end
      check($sformatf("w1_accept_%0d", i), 32'(rdy), 32'd1);
    end
    in_valid[2] = 1'b0;
    repeat (10) step();
    check("w1_took", 32'(g_inst[2].took), 32'd3);

    // Random valid/ready, WIDTH=8 DEPTH=6, 1000 words.
    k = 0; cyc = 0;
    in_data[3] = 8'($urandom_range(0, 255));
    while (k < 1000 && cyc < 40000) begin
      in_valid[3]  = ($urandom_range(0, 3) != 0);
      out_ready[3] = ($urandom_range(0, 2) != 0);
      rdy = in_valid[3] && in_ready[3];
      step();
      cyc++;
      if (rdy) begin
        k++;
        in_data[3] = 8'($urandom_range(0, 255));
      end
    end
    check("rand_accepted", 32'(k), 32'd1000);
    in_valid[3] = 1'b0; out_ready[3] = 1'b1;
    repeat (60) step();
    check("rand_took", 32'(g_inst[3].took), 32'd1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
